// File: rtl/down_counter_reload.sv
// Loadable down-counter with reload register.
// One-shot mode stops at zero and raises DONE; periodic mode reloads from the
// reload register on expiry. BOUT is the same-cycle expiry strobe, TC is its
// registered echo one cycle later.
module down_counter_reload #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         LOAD,
  input  logic [N-1:0] DATA,
  input  logic         CE,
  input  logic         AUTO,
  output logic [N-1:0] O,
  output logic         BOUT,
  output logic         TC,
  output logic         DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nxt;
  logic [N-1:0] r_rld;
  logic [N-1:0] w_rld_nxt;
  logic         r_tc;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_expiry;

  // Expiry: armed counter sitting at zero gets an enable with no load/reset.
  assign w_expiry = (r_state == RUN) & CE & (r_cnt == '0) & ~LOAD & ~RESET;

  // Next-state, count and reload selection; LOAD outranks counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rld_nxt   = r_rld;
    w_done_nxt  = r_done;
    if (LOAD) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = DATA;
      w_rld_nxt   = DATA;
      w_done_nxt  = 1'b0;
    end else if ((r_state == RUN) && CE) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - N'(1);
      end else if (AUTO) begin
        w_cnt_nxt = r_rld;
      end else begin
        w_state_nxt = EXPIRED;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // State, count, reload and status registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rld   <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rld   <= w_rld_nxt;
      r_tc    <= w_expiry;
      r_done  <= w_done_nxt;
    end
  end

  assign O    = r_cnt;
  assign BOUT = w_expiry;
  assign TC   = r_tc;
  assign DONE = r_done;

endmodule

// File: doc/down_counter_reload.md
DOWN_COUNTER_RELOAD -- requirements
Module: down_counter_reload

Interface
REQ-001 SHALL provide parameter: N, 4, counter/data width in bits (N >= 1).
REQ-002 SHALL provide port: CLK  input  1  rising-edge clock; all state updates on this edge.
REQ-003 SHALL provide port: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: LOAD  input  1  load DATA into count and reload registers; arm counter.
REQ-005 SHALL provide port: DATA  input  N  load/reload value.
REQ-006 SHALL provide port: CE  input  1  count enable; one decrement per enabled cycle.
REQ-007 SHALL provide port: AUTO  input  1  1 = reload on expiry (periodic); 0 = stop at zero (one-shot).
REQ-008 SHALL provide port: O  output  N  current count register value.
REQ-009 SHALL provide port: BOUT  output  1  combinational borrow-out/expiry strobe.
REQ-010 SHALL provide port: TC  output  1  registered terminal-count pulse, one cycle after expiry.
REQ-011 SHALL provide port: DONE  output  1  registered; high while one-shot is expired.

Function
REQ-012 SHALL hold internal state register STATE in {IDLE, RUN, EXPIRED} plus N-bit reload register RLD.
REQ-013 SHALL give priority per cycle: RESET > LOAD > CE-driven counting > hold.
REQ-014 LOAD=1 (any state) SHALL set O<=DATA, RLD<=DATA, STATE<=RUN, DONE<=0, TC<=0; CE ignored that cycle.
REQ-015 SHALL define expiry = (STATE==RUN) & CE & (O==0) & ~LOAD & ~RESET.
REQ-016 BOUT SHALL equal expiry, combinationally, same cycle.
REQ-017 RUN, CE=1, O!=0: O<=O-1 (modulo 2^N never reached below 0).
REQ-018 RUN, expiry, AUTO=1: O<=RLD, STATE stays RUN; period = RLD+1 enabled cycles; RLD=0 expires every enabled cycle.
REQ-019 RUN, expiry, AUTO=0: O stays 0, STATE<=EXPIRED, DONE<=1.
REQ-020 TC SHALL be 1 exactly in the cycle after an expiry, else 0; never sticky.
REQ-021 CE=0 in RUN: O, RLD, STATE held; no expiry.
REQ-022 IDLE and EXPIRED: CE and AUTO ignored; O, RLD held; BOUT=0; exit only via LOAD or RESET.
REQ-023 AUTO SHALL be sampled only at expiry; changing AUTO mid-count has no other effect.
REQ-024 LOAD coincident with O==0 & CE SHALL suppress expiry: BOUT=0, no TC next cycle.
REQ-025 LOAD with DATA=0 SHALL enter RUN with O=0; next enabled cycle expires.
REQ-026 All outputs except BOUT SHALL be registered; no combinational path from inputs to O, TC, DONE.

Reset
REQ-027 RESET=1 at a rising edge SHALL set O=0, RLD=0, STATE=IDLE, TC=0, DONE=0, regardless of LOAD/CE.
REQ-028 While RESET=1, BOUT SHALL be 0.
REQ-029 RESET mid-count or coincident with expiry SHALL produce no TC pulse in the following cycle.
REQ-030 After reset, CE alone SHALL NOT cause counting; LOAD required.

Verification (N=4)
REQ-031 Reset, CE=1 for 5 cycles, no LOAD -> O=0, BOUT=0, TC=0, DONE=0 throughout.
REQ-032 LOAD DATA=3, AUTO=0, CE=1 -> O: 3,2,1,0; BOUT=1 in first cycle at O=0; TC=1 next cycle; DONE=1 and O=0 thereafter; further CE gives no BOUT.
REQ-033 LOAD DATA=2, AUTO=1, CE=1 for 9 cycles -> O: 2,1,0,2,1,0,2,1,0; TC pulses every 3rd cycle; DONE stays 0.
REQ-034 LOAD DATA=5, CE toggling 1,0,1,0 -> O decrements only on CE=1 cycles (5,4,4,3,3); no TC.
REQ-035 O=0 in RUN, CE=1 and LOAD DATA=7 same cycle -> BOUT=0, O=7 next, TC=0, DONE=0.
REQ-036 LOAD DATA=15, AUTO=1, count to O=0, assert RESET with CE=1 -> next cycle O=0, TC=0, STATE IDLE; CE then ignored.
